// File: rtl/imem_boot_loader_if.sv
// Boot-loader bus: stream input, imem write port and core-release status.
// The slave modport is the loader side; the master modport is the host/bench side.
interface imem_boot_loader_if #(parameter int ADDR_W = 10);
    logic              start;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              done;
    logic              error;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, core_run, done, error
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_run, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, checksummed program image into imem.
// Holds the core in reset until the checksum of the streamed image matches.
module imem_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOAD, S_CHK, S_RUN, S_ERR
    } state_t;

    state_t            r_state, w_nxt_state;
    logic [CNT_W-1:0]  r_count, w_nxt_count;
    logic [CNT_W-1:0]  r_len, w_nxt_len;
    logic [31:0]       r_sum, w_nxt_sum;
    logic              r_in_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_run, r_done, r_err;
    logic              w_xfer;

    assign w_xfer = bus.in_valid && r_in_ready;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = r_count;
        w_nxt_len   = r_len;
        w_nxt_sum   = r_sum;
        case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
                if (bus.start) w_nxt_state = S_HDR;
            end
            S_HDR: begin
                if (w_xfer) begin
                    if (bus.in_data == 32'd0 || bus.in_data > 32'(MAX_WORDS)) begin
                        w_nxt_state = S_ERR;
                    end else begin
                        w_nxt_state = S_LOAD;
                        w_nxt_len   = CNT_W'(bus.in_data);
                        w_nxt_count = '0;
                        w_nxt_sum   = '0;
                    end
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_nxt_sum   = r_sum + bus.in_data;
                    w_nxt_count = r_count + 1'b1;
                    if (r_count == r_len - 1'b1) w_nxt_state = S_CHK;
                end
            end
            S_CHK: begin
                if (w_xfer) w_nxt_state = (bus.in_data == r_sum) ? S_RUN : S_ERR;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_len      <= '0;
            r_sum      <= '0;
            r_in_ready <= 1'b0;
            r_run      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_count    <= w_nxt_count;
            r_len      <= w_nxt_len;
            r_sum      <= w_nxt_sum;
            r_in_ready <= (w_nxt_state == S_HDR) || (w_nxt_state == S_LOAD) ||
                          (w_nxt_state == S_CHK);
            r_run      <= (w_nxt_state == S_RUN);
            r_done     <= (w_nxt_state == S_RUN);
            r_err      <= (w_nxt_state == S_ERR);
        end
    end

    // Payload write lands one cycle after its transfer, at the pre-increment count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= (r_state == S_LOAD) && w_xfer;
            if ((r_state == S_LOAD) && w_xfer) begin
                r_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_count);
                r_wdata <= bus.in_data;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.core_run   = r_run;
    assign bus.done       = r_done;
    assign bus.error      = r_err;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: image load, bad checksum/length,
// backpressure, mid-load reset and restart from RUN.
module tb_imem_boot_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    imem_boot_loader_if #(.ADDR_W(10)) bus ();

    imem_boot_loader #(.ADDR_W(10), .MAX_WORDS(1024), .BASE_ADDR(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W0 = 32'h0000_0013;
    localparam logic [31:0] W1 = 32'h0010_0093;
    localparam logic [31:0] W2 = 32'h0020_8113;
    localparam logic [31:0] SUM_OK = 32'h0030_81B9;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            n_chk++; n_fail++;
            $display("FAIL xfer_timeout: in_ready=%b required 1 for word %h", bus.in_ready, d);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_image(input logic [31:0] chk, input int gap);
        send_word(32'd3, gap);
        send_word(W0, gap);
        send_word(W1, gap);
        send_word(W2, gap);
        send_word(chk, 0);
    endtask

    task automatic test_reset();
        n_chk++;
        if ({bus.in_ready, bus.imem_we, bus.core_run, bus.done, bus.error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {bus.in_ready, bus.imem_we, bus.core_run, bus.done, bus.error});
        end
    endtask

    task automatic test_load(input string nm, input int gap);
        logic [31:0] exp_d[3];
        exp_d[0] = W0; exp_d[1] = W1; exp_d[2] = W2;
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_image(SUM_OK, gap);
        n_chk++;
        if ({bus.core_run, bus.done, bus.error} !== 3'b110) begin
            n_fail++;
            $display("FAIL %s_status: run/done/err=%b required 110", nm,
                     {bus.core_run, bus.done, bus.error});
        end
        n_chk++;
        if (wr_addr.size() != 3) begin
            n_fail++;
            $display("FAIL %s_wr_count: got %0d required 3", nm, wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (wr_addr[i] !== 10'(i) || wr_data[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL %s_wr%0d: addr=%0d data=%h required addr=%0d data=%h",
                             nm, i, wr_addr[i], wr_data[i], i, exp_d[i]);
                end
            end
        end
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready_run: in_ready=%b required 0", nm, bus.in_ready);
        end
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        n_chk++;
        if ({bus.core_run, bus.done, bus.in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL restart_clear: run/done/ready=%b required 001",
                     {bus.core_run, bus.done, bus.in_ready});
        end
        send_image(32'h0030_81B8, 0);
        n_chk++;
        if ({bus.core_run, bus.done, bus.error} !== 3'b001) begin
            n_fail++;
            $display("FAIL bad_chk_status: run/done/err=%b required 001",
                     {bus.core_run, bus.done, bus.error});
        end
    endtask

    task automatic test_bad_len(input logic [31:0] n_hdr);
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_word(n_hdr, 0);
        n_chk++;
        if ({bus.core_run, bus.done, bus.error, bus.in_ready} !== 4'b0010) begin
            n_fail++;
            $display("FAIL bad_len_%0d: run/done/err/ready=%b required 0010", n_hdr,
                     {bus.core_run, bus.done, bus.error, bus.in_ready});
        end
        @(posedge clk); #1;
        n_chk++;
        if (wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL bad_len_%0d_we: writes=%0d required 0", n_hdr, wr_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_word(32'd3, 0);
        send_word(W0, 0);
        send_word(W1, 0);
        rst = 1'b0;
        #1;
        n_chk++;
        if ({bus.in_ready, bus.imem_we, bus.core_run, bus.done, bus.error} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b required 00000",
                     {bus.in_ready, bus.imem_we, bus.core_run, bus.done, bus.error});
        end
        @(posedge clk); #2;
        rst = 1'b1;
        test_load("after_rst", 0);
    endtask

    task automatic test_start_in_run();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'd3;
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_start_ready: in_ready=%b required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.in_valid = 1'b0;
        n_chk++;
        if ({bus.core_run, bus.done, bus.error, bus.in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL run_start_hdr: run/done/err/ready=%b required 0001",
                     {bus.core_run, bus.done, bus.error, bus.in_ready});
        end
        wr_addr.delete(); wr_data.delete();
        send_word(32'd2, 0);
        send_word(32'hAAAA_0000, 0);
        send_word(32'h0000_5555, 0);
        send_word(32'hAAAA_5555, 0);
        n_chk++;
        if ({bus.core_run, bus.done, bus.error} !== 3'b110) begin
            n_fail++;
            $display("FAIL run_start_status: run/done/err=%b required 110",
                     {bus.core_run, bus.done, bus.error});
        end
        n_chk++;
        if (wr_addr.size() != 2) begin
            n_fail++;
            $display("FAIL run_start_wr_count: got %0d required 2", wr_addr.size());
        end else if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'hAAAA_0000 ||
                     wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h0000_5555) begin
            n_fail++;
            $display("FAIL run_start_wr: %0d:%h %0d:%h required 0:aaaa0000 1:00005555",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        test_load("load", 0);
        test_bad_checksum();
        test_bad_len(32'd0);
        test_bad_len(32'd1025);
        test_load("bp", 2);
        test_reset_mid();
        test_start_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
